// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : N-channel valid/ready multiplexer with a registered output
//               stage. Channels are arbitrated either round-robin (MODE 0,
//               search starts after the last granted channel) or by fixed
//               priority (MODE 1, lowest index wins). The output register
//               refills in the same edge it is popped, so a continuously
//               ready sink sees one beat per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    // Pointer value after reset: the last channel, so the first
    // round-robin search starts at channel 0.
    localparam logic [SELW-1:0] C_PTR_RESET = SELW'(N - 1);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SELW-1:0]  r_out_sel;
    logic [SELW-1:0]  r_ptr;

    logic             w_load_en;
    logic [N-1:0]     w_grant;
    logic             w_found;
    logic [SELW-1:0]  w_gidx;
    logic [WIDTH-1:0] w_sel_data;

    // The output register can take a new beat when it is empty or being popped.
    assign w_load_en = !r_out_valid || out_ready;

    if (MODE == 1) begin : g_fixed
        // Fixed priority: the lowest-index valid channel wins.
        always_comb begin
            w_grant = '0;
            w_found = 1'b0;
            w_gidx  = '0;
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && !w_found) begin
                    w_found    = 1'b1;
                    w_gidx     = SELW'(i);
                    w_grant[i] = 1'b1;
                end
            end
        end
    end else begin : g_rr
        // Round-robin: search ptr+1, ptr+2, ... wrapping from N-1 to 0.
        always_comb begin
            w_grant = '0;
            w_found = 1'b0;
            w_gidx  = '0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (int'(r_ptr) + k) % N;
                if (in_valid[idx] && !w_found) begin
                    w_found      = 1'b1;
                    w_gidx       = SELW'(idx);
                    w_grant[idx] = 1'b1;
                end
            end
        end
    end

    // Data of the granted channel; only consumed when a grant exists.
    assign w_sel_data = in_data[int'(w_gidx)*WIDTH +: WIDTH];

    // Accept only from the granted channel, and never while in reset.
    assign in_ready = w_grant & {N{w_load_en && !reset}};

    // Output stage and arbitration pointer; reset discards any pending beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= C_PTR_RESET;
        end else if (w_load_en) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_gidx;
                r_ptr       <= w_gidx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Scoreboard bench for rr_mux_arbiter (N=4, WIDTH=32). One
//               instance per arbitration mode; a monitor pops expected beats
//               whenever the active instance's output is accepted downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } beat_t;

    logic         clk;
    logic         reset;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic         out_ready;
    logic [31:0]  chd [4];

    logic [3:0]   rdy0, rdy1;
    logic [31:0]  dat0, dat1;
    logic         val0, val1;
    logic [1:0]   sel0, sel1;

    logic         active;
    logic [3:0]   a_ready;
    logic [31:0]  a_data;
    logic         a_valid;
    logic [1:0]   a_sel;

    beat_t        sb_q [$];
    int           checks;
    int           errors;

    assign in_data = {chd[3], chd[2], chd[1], chd[0]};
    assign a_ready = active ? rdy1 : rdy0;
    assign a_data  = active ? dat1 : dat0;
    assign a_valid = active ? val1 : val0;
    assign a_sel   = active ? sel1 : sel0;

    rr_mux_arbiter #(.WIDTH(32), .N(4), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .out_data(dat0), .out_valid(val0),
        .out_ready(out_ready), .out_sel(sel0)
    );

    rr_mux_arbiter #(.WIDTH(32), .N(4), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .out_data(dat1), .out_valid(val1),
        .out_ready(out_ready), .out_sel(sel1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] oh_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Apply one cycle of stimulus; exp_rdy is the hand-computed grant.
    task automatic step(input logic [3:0] v, input logic r, input logic [3:0] exp_rdy,
                        input string nm);
        beat_t b;
        in_valid  = v;
        out_ready = r;
        #1;
        chk(32'(a_ready), 32'(exp_rdy), {nm, "_in_ready"});
        if (exp_rdy != 4'b0000) begin
            b.sel  = oh_idx(exp_rdy);
            b.data = chd[oh_idx(exp_rdy)];
            sb_q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        active    = 1'b0;
        reset     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) chd[i] = 32'h1111_1111 * (i + 1);

        // Scoreboard monitor: compare every beat accepted downstream.
        fork
            forever begin
                @(negedge clk);
                if (!reset && a_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk({30'd0, a_sel}, 32'hFFFF_FFFF, "unexpected_beat");
                    end else begin
                        beat_t e;
                        e = sb_q.pop_front();
                        chk({30'd0, a_sel}, {30'd0, e.sel}, "beat_sel");
                        chk(a_data, e.data, "beat_data");
                    end
                end
            end
        join_none

        // Reset values appear before any clock edge.
        #1 reset = 1'b1;
        #2;
        chk({31'd0, a_valid}, 32'd0, "rst_out_valid");
        chk(a_data, 32'd0, "rst_out_data");
        chk({30'd0, a_sel}, 32'd0, "rst_out_sel");
        chk(32'(a_ready), 32'd0, "rst_in_ready");
        @(posedge clk);
        #1 reset = 1'b0;

        // Round-robin with all channels valid: 0,1,2,3,0.
        step(4'b1111, 1'b1, 4'b0001, "rr0");
        step(4'b1111, 1'b1, 4'b0010, "rr1");
        step(4'b1111, 1'b1, 4'b0100, "rr2");
        step(4'b1111, 1'b1, 4'b1000, "rr3");
        step(4'b1111, 1'b1, 4'b0001, "rr4");

        // Downstream stall for 3 cycles: nothing accepted, output frozen.
        for (int c = 0; c < 3; c++) begin
            step(4'b0110, 1'b0, 4'b0000, "stall");
            chk({31'd0, a_valid}, 32'd1, "stall_valid");
            chk({30'd0, a_sel}, 32'd0, "stall_sel");
            chk(a_data, 32'h1111_1111, "stall_data");
        end
        step(4'b0110, 1'b1, 4'b0010, "unstall");
        step(4'b0000, 1'b1, 4'b0000, "drain1");

        // Wrap-around from ptr=3 to channel 1, then ptr=1 selects ch2 next.
        step(4'b1000, 1'b1, 4'b1000, "wrap_ch3");
        step(4'b0010, 1'b1, 4'b0010, "wrap_ch1");
        step(4'b1111, 1'b1, 4'b0100, "after_wrap");
        step(4'b0000, 1'b1, 4'b0000, "drain2");

        // Single beat then idle: valid drops, data held.
        chd[2] = 32'hAAAA_AAAA;
        step(4'b0100, 1'b1, 4'b0100, "single");
        chk({31'd0, a_valid}, 32'd1, "single_valid");
        step(4'b0000, 1'b1, 4'b0000, "idle1");
        chk({31'd0, a_valid}, 32'd0, "idle_valid");
        chk(a_data, 32'hAAAA_AAAA, "idle_data_held");
        chk({30'd0, a_sel}, 32'd2, "idle_sel_held");
        step(4'b0000, 1'b1, 4'b0000, "idle2");
        chk(a_data, 32'hAAAA_AAAA, "idle_data_held2");
        chd[2] = 32'h3333_3333;

        // Asynchronous reset while a beat is pending.
        step(4'b0001, 1'b1, 4'b0001, "pre_rst");
        chk({31'd0, a_valid}, 32'd1, "pre_rst_valid");
        out_ready = 1'b0;
        in_valid  = 4'b0000;
        #2 reset = 1'b1;
        #1;
        chk({31'd0, a_valid}, 32'd0, "async_rst_valid");
        chk(a_data, 32'd0, "async_rst_data");
        chk({30'd0, a_sel}, 32'd0, "async_rst_sel");
        in_valid = 4'b1111;
        #1;
        chk(32'(a_ready), 32'd0, "async_rst_in_ready");
        @(posedge clk);
        #1 reset = 1'b0;
        sb_q.delete();
        step(4'b1111, 1'b1, 4'b0001, "post_rst");
        step(4'b0000, 1'b1, 4'b0000, "drain3");

        // Fixed priority instance.
        active = 1'b1;
        pulse_reset();
        for (int c = 0; c < 4; c++) step(4'b0101, 1'b1, 4'b0001, "fp_ch0");
        step(4'b0100, 1'b1, 4'b0100, "fp_ch2");
        step(4'b0000, 1'b1, 4'b0000, "fp_drain");
        step(4'b0000, 1'b1, 4'b0000, "fp_idle");
        chk({31'd0, a_valid}, 32'd0, "fp_idle_valid");

        chk(32'(sb_q.size()), 32'd0, "sb_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width per channel in bits.
REQ-002 SHALL have parameter N, default 4, meaning input channel count (N >= 2).
REQ-003 SHALL have parameter MODE, default 0, meaning arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 SHALL have port clk  input  1  the single clock, with all state updating on its rising edge.
REQ-005 SHALL have port reset  input  1  an asynchronous, active-high reset.
REQ-006 SHALL have port in_data  input  N*WIDTH  packed channel data, with channel i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  N  per-channel request.
REQ-008 SHALL have port in_ready  output  N  per-channel accept, combinational.
REQ-009 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-010 SHALL have port out_valid  output  1  registered output-beat-present flag.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_sel  output  clog2(N)  registered index of the channel that supplied out_data.

Function
REQ-013 SHALL define load_en = !out_valid || out_ready.
REQ-014 SHALL compute a one-hot grant combinationally from in_valid, MODE and pointer ptr; grant SHALL be all-zero when no in_valid bit is set.
REQ-015 In MODE 0, SHALL grant the first valid index searching ptr+1, ptr+2, ... with wrap from N-1 to 0.
REQ-016 In MODE 1, SHALL grant the lowest valid index, and SHALL keep ptr updated but ignore it.
REQ-017 SHALL drive in_ready[i] = load_en && grant[i]; at most one in_ready bit SHALL be high per cycle.
REQ-018 A transfer on channel g occurs when in_valid[g] && in_ready[g]; on that edge, out_data <= channel g data, out_sel <= g, out_valid <= 1, ptr <= g.
REQ-019 When load_en is high and no channel is valid, SHALL set out_valid <= 0, with out_data, out_sel and ptr held.
REQ-020 When load_en is low (out_valid=1, out_ready=0), out_data, out_sel, out_valid and ptr SHALL all hold.
REQ-021 Latency from input transfer to out_valid SHALL be 1 cycle; sustained throughput SHALL be 1 beat/cycle when out_ready stays high.
REQ-022 Simultaneous downstream pop and input transfer SHALL replace the output beat in the same edge, with no bubble.
REQ-023 No combinational path SHALL exist from out_ready to out_data/out_valid/out_sel; the only such path is from out_ready to in_ready.
REQ-024 Upstream SHALL hold in_valid and data stable until accepted; the block SHALL NOT rely on in_valid depending on in_ready.
REQ-025 Round-robin fairness: with all N channels continuously valid, each channel SHALL be granted exactly once per N consecutive transfers.

Reset
REQ-026 On reset assertion, out_valid, out_data and out_sel SHALL go to 0 immediately, without waiting for clk.
REQ-027 On reset assertion, ptr SHALL go to N-1 immediately, so the first MODE 0 grant searches from index 0.
REQ-028 While reset is high, in_ready SHALL be all 0.
REQ-029 A beat held at out_valid when reset asserts SHALL be discarded, with no replay after release.
REQ-030 First transfer possible on the first rising clk edge after reset deasserts.

Verification (N=4, WIDTH=32)
REQ-031 SHALL cover: MODE 0, all in_valid=4'b1111, data ch i = 32'h1111_1111*(i+1), out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data matching each channel.
REQ-032 SHALL cover: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b0110 -> in_ready=0000 and out_data/out_sel stable all 3 cycles.
REQ-033 SHALL cover: MODE 1, in_valid=4'b0101 for 4 cycles -> out_sel=0 every beat, then after ch0 drops, ch2 granted next cycle.
REQ-034 SHALL cover: MODE 0, ptr=3 after a ch3 transfer, only in_valid[1] set -> ch1 granted (wrap-around), ptr becomes 1.
REQ-035 SHALL cover: a single ch2 beat 32'hAAAA_AAAA then in_valid=0, out_ready=1 -> out_valid high 1 cycle, then 0 with out_data held at 32'hAAAA_AAAA.
REQ-036 SHALL cover: reset asserted mid-cycle while out_valid=1 -> out_valid=0, out_data=0, out_sel=0 before the next clk edge, with next grant to ch0 after release.
